// File: rtl/r5p_mem_rsp_if.sv
// Memory-port bundle between an initiator (master) and the r5p_mem_rsp
// responder (slave).
//
// Handshake: the initiator raises req and holds req, wen, adr, ben and wdt
// stable until a cycle in which ack=1. The transfer completes in that cycle.
// A write lands on the rising edge that ends that cycle. rdt and err are
// only meaningful while ack=1 and read as zero otherwise. Dropping req
// before ack abandons the transfer without side effects.
interface r5p_mem_rsp_if #(
  parameter int AW = 32,
  parameter int BW = 4
);
  logic            req;
  logic            wen;
  logic [AW-1:0]   adr;
  logic [BW-1:0]   ben;
  logic [BW*8-1:0] wdt;
  logic [BW*8-1:0] rdt;
  logic            ack;
  logic            err;

  modport master (
    output req, wen, adr, ben, wdt,
    input  rdt, ack, err
  );

  modport slave (
    input  req, wen, adr, ben, wdt,
    output rdt, ack, err
  );
endinterface

// File: rtl/r5p_mem_rsp.sv
// Simple memory responder: a byte-enabled word memory with an asynchronous
// read port and a configurable number of wait cycles before acknowledging.
// Addresses at or above SIZE are acknowledged with err=1. They return zero
// and never touch memory.
module r5p_mem_rsp #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int BW   = DW/8,
  parameter int SIZE = 4096,
  parameter int LAT  = 0
) (
  input  logic           clk,
  input  logic           rst,
  r5p_mem_rsp_if.slave   bus,
  output logic           dbg_state,   // 1 while waiting for the ack cycle
  output logic [3:0]     dbg_cnt      // wait-cycle counter
);

  localparam int AB    = $clog2(SIZE);   // byte-address bits inside memory
  localparam int OB    = $clog2(BW);     // byte-offset bits inside a word
  localparam int WORDS = SIZE / BW;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  logic [BW*8-1:0] mem [WORDS];
  logic [AB-OB-1:0] widx;
  logic             in_range;
  logic             ack_i;
  logic             wr_en;

  assign widx     = bus.adr[AB-1:OB];
  assign in_range = ((bus.adr >> AB) == '0);
  assign wr_en    = ack_i & bus.wen & in_range;

  assign bus.ack = ack_i;
  assign bus.err = ack_i & ~in_range;
  assign bus.rdt = (ack_i && in_range) ? mem[widx] : '0;

  // The byte offset within a word plays no role in addressing.
  if (OB > 0) begin : g_lo_bits
    logic unused_lo;
    assign unused_lo = ^bus.adr[OB-1:0];
  end

  // Byte-masked write on the edge that ends the ack cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BW; i++) begin
        if (bus.ben[i]) mem[widx][i*8 +: 8] <= bus.wdt[i*8 +: 8];
      end
    end
  end

  if (LAT == 0) begin : g_comb
    // Zero wait cycles: acknowledge in the request cycle, no state kept.
    assign ack_i     = bus.req & ~rst;
    assign dbg_state = 1'b0;
    assign dbg_cnt   = 4'd0;
  end else begin : g_fsm
    localparam logic [3:0] LAT4 = 4'(LAT);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] radr_q, radr_d;
    logic          rwen_q, rwen_d;
    logic          ack_d;

    // State, counter and captured request attributes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        radr_q  <= '0;
        rwen_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        radr_q  <= radr_d;
        rwen_q  <= rwen_d;
      end
    end

    // Next state and combinational ack; a changed address or direction
    // mid-wait restarts the count so stale timing never acks a new request.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      radr_d  = radr_q;
      rwen_d  = rwen_q;
      ack_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
            radr_d  = bus.adr;
            rwen_d  = bus.wen;
          end
        end
        WAIT: begin
          if (!bus.req) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if ((bus.adr != radr_q) || (bus.wen != rwen_q)) begin
            cnt_d  = 4'd1;
            radr_d = bus.adr;
            rwen_d = bus.wen;
          end else if (cnt_q < LAT4) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            ack_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    assign ack_i     = ack_d;
    assign dbg_state = (state_q == WAIT);
    assign dbg_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_r5p_mem_rsp.sv
// Bench for r5p_mem_rsp: three instances (LAT=0 SIZE=4096, LAT=2 SIZE=256,
// LAT=3 SIZE=256) exercised by a directed vector table, hand-written
// multi-cycle sequences and random transfers checked against a
// transfer-level memory model.
module tb_r5p_mem_rsp;

  localparam int N = 3;

  logic clk;
  logic rst;

  logic        req_s  [N];
  logic        wen_s  [N];
  logic [31:0] adr_s  [N];
  logic [3:0]  ben_s  [N];
  logic [31:0] wdt_s  [N];
  logic [31:0] rdt_s  [N];
  logic        ack_s  [N];
  logic        err_s  [N];
  logic        dbg_state_s [N];
  logic [3:0]  dbg_cnt_s   [N];

  int checks;
  int errors;

  // Reference memory: word contents plus a per-byte "has been written" mask.
  logic [31:0] mdl [N][1024];
  logic [3:0]  kn  [N][1024];

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic int size_of(input int d);
    return (d == 0) ? 4096 : 256;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    r5p_mem_rsp_if #(.AW(32), .BW(4)) bus ();
    assign bus.req = req_s[g];
    assign bus.wen = wen_s[g];
    assign bus.adr = adr_s[g];
    assign bus.ben = ben_s[g];
    assign bus.wdt = wdt_s[g];
    assign rdt_s[g] = bus.rdt;
    assign ack_s[g] = bus.ack;
    assign err_s[g] = bus.err;
    r5p_mem_rsp #(
      .AW(32), .DW(32), .BW(4),
      .SIZE((g == 0) ? 4096 : 256),
      .LAT((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state_s[g]),
      .dbg_cnt   (dbg_cnt_s[g])
    );
  end

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transfer on instance d: hold the request until ack (bounded),
  // check latency, idle zeros and returned data against the model, then
  // update the model for a completed in-range write.
  task automatic do_xfer(input int d, input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
    int n;
    bit got;
    bit inr;
    int idx;
    logic [31:0] m32;
    req_s[d] = 1'b1;
    wen_s[d] = w;
    adr_s[d] = a;
    ben_s[d] = b;
    wdt_s[d] = wd;
    n = 0;
    got = 1'b0;
    rd = '0;
    er = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack_s[d]) begin
        got = 1'b1;
        rd = rdt_s[d];
        er = err_s[d];
      end else begin
        chk("rdt_zero_no_ack", rdt_s[d], 32'h0);
        chk("err_zero_no_ack", {31'h0, err_s[d]}, 32'h0);
      end
      @(posedge clk);
      #1;
    end
    req_s[d] = 1'b0;
    if (!got) begin
      chk("ack_timeout", 32'(n), 32'(lat_of(d) + 1));
    end else begin
      chk("ack_latency", 32'(n), 32'(lat_of(d) + 1));
      inr = (a < 32'(size_of(d)));
      idx = int'((a % 32'(size_of(d))) >> 2);
      chk("err_flag", {31'h0, er}, {31'h0, !inr});
      if (!inr) begin
        chk("rdt_on_err", rd, 32'h0);
      end else if (!w && kn[d][idx] != 4'h0) begin
        m32 = {{8{kn[d][idx][3]}}, {8{kn[d][idx][2]}}, {8{kn[d][idx][1]}}, {8{kn[d][idx][0]}}};
        chk("read_data", rd & m32, mdl[d][idx] & m32);
      end
      if (inr && w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) begin
            mdl[d][idx][i*8 +: 8] = wd[i*8 +: 8];
            kn[d][idx][i] = 1'b1;
          end
        end
      end
    end
  endtask

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] wd;
    logic [31:0] exp_rdt;
    bit          exp_err;
    bit          cmp_rdt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] rd;
    logic er;
    int n;
    bit got;

    checks = 0;
    errors = 0;
    for (int d = 0; d < N; d++) begin
      for (int k = 0; k < 1024; k++) begin
        mdl[d][k] = '0;
        kn[d][k] = 4'h0;
      end
      req_s[d] = 1'b0;
      wen_s[d] = 1'b0;
      adr_s[d] = '0;
      ben_s[d] = '0;
      wdt_s[d] = '0;
    end

    // Directed vectors: {dut, write, adr, ben, wdt, expected rdt, expected err, compare rdt}
    tbl[0]  = '{0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{0, 1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[2]  = '{0, 1'b0, 32'h13,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[3]  = '{0, 1'b1, 32'h0,    4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0,        1'b1, 1'b1};
    tbl[5]  = '{0, 1'b0, 32'h0,    4'hF, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
    tbl[6]  = '{0, 1'b0, 32'h1FFC, 4'hF, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[7]  = '{2, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[8]  = '{2, 1'b1, 32'h10,   4'h2, 32'h0000AA00, 32'h0,        1'b0, 1'b0};
    tbl[9]  = '{2, 1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADAAEF, 1'b0, 1'b1};
    tbl[10] = '{1, 1'b1, 32'h20,   4'hF, 32'h11223344, 32'h0,        1'b0, 1'b0};
    tbl[11] = '{1, 1'b1, 32'h20,   4'h0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
    tbl[12] = '{1, 1'b0, 32'h20,   4'hF, 32'h0,        32'h11223344, 1'b0, 1'b1};
    tbl[13] = '{1, 1'b1, 32'h0,    4'hF, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    tbl[14] = '{1, 1'b1, 32'h100,  4'hF, 32'h5A5A5A5A, 32'h0,        1'b1, 1'b1};
    tbl[15] = '{1, 1'b0, 32'h0,    4'hF, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[16] = '{2, 1'b1, 32'h1,    4'h9, 32'h77665544, 32'h0,        1'b0, 1'b0};

    // Reset block: outputs must be quiet even with a request on the LAT=0 port.
    rst = 1'b1;
    req_s[0] = 1'b1;
    adr_s[0] = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      chk("reset_ack", {31'h0, ack_s[d]}, 32'h0);
      chk("reset_err", {31'h0, err_s[d]}, 32'h0);
      chk("reset_rdt", rdt_s[d], 32'h0);
      chk("reset_state", {31'h0, dbg_state_s[d]}, 32'h0);
      chk("reset_cnt", {28'h0, dbg_cnt_s[d]}, 32'h0);
    end
    @(posedge clk);
    #1;
    req_s[0] = 1'b0;
    rst = 1'b0;

    // Table-driven directed transfers.
    for (int t = 0; t < 17; t++) begin
      do_xfer(tbl[t].d, tbl[t].w, tbl[t].a, tbl[t].b, tbl[t].wd, rd, er);
      chk($sformatf("tbl%0d_err", t), {31'h0, er}, {31'h0, tbl[t].exp_err});
      if (tbl[t].cmp_rdt) chk($sformatf("tbl%0d_rdt", t), rd, tbl[t].exp_rdt);
    end

    // Abandoned request on LAT=2: one cycle of a write, then dropped.
    do_xfer(1, 1'b1, 32'h30, 4'hF, 32'h55AA55AA, rd, er);
    req_s[1] = 1'b1; wen_s[1] = 1'b1; adr_s[1] = 32'h30; ben_s[1] = 4'hF; wdt_s[1] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("abandon_ack1", {31'h0, ack_s[1]}, 32'h0);
    @(posedge clk); #1;
    req_s[1] = 1'b0;
    @(negedge clk);
    chk("abandon_ack2", {31'h0, ack_s[1]}, 32'h0);
    @(posedge clk); #1;
    do_xfer(1, 1'b0, 32'h30, 4'hF, 32'h0, rd, er);
    chk("abandon_mem", rd, 32'h55AA55AA);

    // Address change mid-wait on LAT=2: ack two cycles after the change.
    do_xfer(1, 1'b1, 32'h10, 4'hF, 32'hAAAA0001, rd, er);
    do_xfer(1, 1'b1, 32'h14, 4'hF, 32'hBBBB0002, rd, er);
    req_s[1] = 1'b1; wen_s[1] = 1'b0; adr_s[1] = 32'h10; ben_s[1] = 4'hF;
    @(negedge clk);
    chk("chg_first_ack", {31'h0, ack_s[1]}, 32'h0);
    @(posedge clk); #1;
    adr_s[1] = 32'h14;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack_s[1]) begin
        got = 1'b1;
        chk("chg_rdt", rdt_s[1], 32'hBBBB0002);
      end
      @(posedge clk); #1;
    end
    req_s[1] = 1'b0;
    chk("chg_latency", 32'(n), 32'd3);

    // Reset during the wait of a write on LAT=3: no write, then a full-latency restart.
    do_xfer(2, 1'b1, 32'h40, 4'hF, 32'h0F0F0F0F, rd, er);
    req_s[2] = 1'b1; wen_s[2] = 1'b1; adr_s[2] = 32'h40; ben_s[2] = 4'hF; wdt_s[2] = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("prerst_ack", {31'h0, ack_s[2]}, 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    req_s[0] = 1'b1; wen_s[0] = 1'b0; adr_s[0] = 32'h10;
    @(negedge clk);
    chk("midrst_ack", {31'h0, ack_s[2]}, 32'h0);
    chk("midrst_state", {31'h0, dbg_state_s[2]}, 32'h0);
    chk("midrst_cnt", {28'h0, dbg_cnt_s[2]}, 32'h0);
    chk("midrst_ack0", {31'h0, ack_s[0]}, 32'h0);
    chk("midrst_rdt0", rdt_s[0], 32'h0);
    wen_s[2] = 1'b0;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    rst = 1'b0;
    do_xfer(2, 1'b0, 32'h40, 4'hF, 32'h0, rd, er);
    chk("rst_abort_mem", rd, 32'h0F0F0F0F);
    do_xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, er);
    chk("mem_kept_over_rst", rd, 32'hDEADBEEF);

    // Random transfers against the model.
    for (int k = 0; k < 120; k++) begin
      int d;
      bit w;
      logic [31:0] a;
      d = int'($urandom_range(0, N - 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = 32'(size_of(d)) + 32'($urandom_range(0, 255));
      else
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_xfer(d, w, a, 4'($urandom_range(0, 15)), $urandom, rd, er);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
